baud_cfg_arbiter: RTL and testbench

- Shares one baud_generator instance between NUM_REQ requesters (UART TX/RX channels, test harness) that each need to set the shared baud rate.
- Arbitrates config requests round-robin and validates the requested rate.
- Safely reprograms the generator: disable, settle, load, re-enable, confirm first tick.
- Acknowledges or rejects each request. Sits between channel controllers and the generator's en/baud_rate/baud_tick/baud_cycle pins.

---
 rtl/baud_cfg_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_baud_cfg_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// baud_cfg_arbiter
//
// Shares one baud generator between NUM_REQ requesters. Requests are
// arbitrated round-robin, validated, and applied to the generator with a
// safe disable / settle / load / enable / first-tick sequence. Each request
// is answered by exactly one ack or err pulse.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   req            per-requester request level, held until ack/err
//   req_baud       requested rates, requester i at [32i+31:32i]
//   ack            one-hot 1-cycle pulse: request applied
//   err            one-hot 1-cycle pulse: request rejected or timed out
//   err_timeout    qualifies err: 1 = first-tick timeout, 0 = invalid rate
//   busy           high in every state except IDLE
//   owner          index of the last requester granted
//   cur_baud       rate currently running on the generator (0 if none)
//   gen_en         generator enable
//   gen_baud_rate  generator rate input
//   gen_baud_tick  generator tick output
//   gen_baud_cycle generator divisor output
// -----------------------------------------------------------------------------
module baud_cfg_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SYS_CLK       = 1000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TO_SLACK      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [32*NUM_REQ-1:0]      req_baud,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         err,
  output logic                       err_timeout,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic [31:0]                cur_baud,
  output logic                       gen_en,
  output logic [31:0]                gen_baud_rate,
  input  logic                       gen_baud_tick,
  input  logic [31:0]                gen_baud_cycle
);

  localparam int unsigned IDX_W    = $clog2(NUM_REQ);
  localparam logic [31:0] MAX_RATE = 32'(SYS_CLK / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DISABLE,
    S_LOAD,
    S_ENABLE,
    S_WAIT_TICK,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [31:0]      sel_rate;
  logic             running;
  logic [3:0]       settle_cnt;
  logic [32:0]      to_limit;
  logic [32:0]      wait_cnt;
  logic             to_flag;

  // Round-robin pick: first set req bit at or after rr_ptr, wrapping.
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W:0]   cand;

  // NOTE: every variable assigned in always_comb gets a default at the top of
  // the block so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    // Walk from the farthest offset down so the nearest set bit wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (req[cand[IDX_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // First-tick limit: 2*divisor + slack, saturating at 33 bits of ones.
  logic [33:0] to_sum;
  logic [32:0] to_next;
  always_comb begin
    to_sum  = {1'b0, gen_baud_cycle, 1'b0} + 34'(TO_SLACK);
    to_next = to_sum[33] ? '1 : to_sum[32:0];
  end

  logic [IDX_W-1:0] next_ptr;
  assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  assign busy = (state != S_IDLE);

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      sel_rate      <= '0;
      running       <= 1'b0;
      settle_cnt    <= '0;
      to_limit      <= '0;
      wait_cnt      <= '0;
      to_flag       <= 1'b0;
      ack           <= '0;
      err           <= '0;
      err_timeout   <= 1'b0;
      owner         <= '0;
      cur_baud      <= '0;
      gen_en        <= 1'b0;
      gen_baud_rate <= '0;
    end else begin
      // Pulses last exactly one cycle.
      ack         <= '0;
      err         <= '0;
      err_timeout <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            owner    <= gnt_idx;
            sel_rate <= req_baud[32*gnt_idx +: 32];
            state    <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (sel_rate == '0 || sel_rate > MAX_RATE) begin
            to_flag <= 1'b0;
            state   <= S_ERR;
          end else if (running && sel_rate == cur_baud) begin
            // Already running at this rate: acknowledge without a restart.
            state <= S_DONE;
          end else begin
            gen_en     <= 1'b0;
            running    <= 1'b0;
            settle_cnt <= '0;
            state      <= S_DISABLE;
          end
        end

        S_DISABLE: begin
          if (settle_cnt == 4'(SETTLE_CYCLES - 1)) state <= S_LOAD;
          else settle_cnt <= settle_cnt + 1'b1;
        end

        S_LOAD: begin
          gen_baud_rate <= sel_rate;
          state         <= S_ENABLE;
        end

        S_ENABLE: begin
          // The divisor reflects the rate loaded in the previous cycle.
          gen_en   <= 1'b1;
          to_limit <= to_next;
          wait_cnt <= 33'd1;
          state    <= S_WAIT_TICK;
        end

        S_WAIT_TICK: begin
          if (gen_baud_tick) begin
            state <= S_DONE;
          end else if (wait_cnt >= to_limit) begin
            gen_en   <= 1'b0;
            cur_baud <= '0;
            to_flag  <= 1'b1;
            state    <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DONE: begin
          ack[owner] <= 1'b1;
          cur_baud   <= sel_rate;
          running    <= 1'b1;
          rr_ptr     <= next_ptr;
          state      <= S_IDLE;
        end

        S_ERR: begin
          err[owner]  <= 1'b1;
          err_timeout <= to_flag;
          rr_ptr      <= next_ptr;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_baud_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_baud_cfg_arbiter
//
// Self-checking bench for baud_cfg_arbiter with a behavioural baud generator
// (divisor = SYS_CLK / rate, tick every divisor cycles while enabled). Every
// expected ack/err pulse is queued when a request is driven and compared when
// the pulse appears.
// -----------------------------------------------------------------------------
module tb_baud_cfg_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SYS_CLK = 1000;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req;
  logic [32*NUM_REQ-1:0]  req_baud;
  logic [NUM_REQ-1:0]     ack;
  logic [NUM_REQ-1:0]     err;
  logic                   err_timeout;
  logic                   busy;
  logic [1:0]             owner;
  logic [31:0]            cur_baud;
  logic                   gen_en;
  logic [31:0]            gen_baud_rate;
  logic                   gen_baud_tick;
  logic [31:0]            gen_baud_cycle;

  always #5 clk = ~clk;

  baud_cfg_arbiter #(
    .NUM_REQ(NUM_REQ), .SYS_CLK(SYS_CLK), .SETTLE_CYCLES(2), .TO_SLACK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_baud(req_baud),
    .ack(ack), .err(err), .err_timeout(err_timeout), .busy(busy),
    .owner(owner), .cur_baud(cur_baud), .gen_en(gen_en),
    .gen_baud_rate(gen_baud_rate), .gen_baud_tick(gen_baud_tick),
    .gen_baud_cycle(gen_baud_cycle)
  );

  // Behavioural baud generator; tick_kill suppresses ticks for timeout tests.
  logic        tick_kill;
  logic [31:0] gcnt;

  always_comb
    gen_baud_cycle = (gen_baud_rate == 32'd0) ? 32'd0 : 32'(SYS_CLK) / gen_baud_rate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt          <= '0;
      gen_baud_tick <= 1'b0;
    end else if (!gen_en) begin
      gcnt          <= '0;
      gen_baud_tick <= 1'b0;
    end else if (gcnt + 32'd1 >= gen_baud_cycle) begin
      gcnt          <= '0;
      gen_baud_tick <= !tick_kill;
    end else begin
      gcnt          <= gcnt + 32'd1;
      gen_baud_tick <= 1'b0;
    end
  end

  typedef struct {
    int          idx;
    logic [31:0] rate;
    logic        is_err;
    logic        to;
    logic [31:0] cur;
    logic        en;
    logic        steady;   // same-rate request: fast ack, gen_en never drops
  } vec_t;

  typedef struct {
    int          idx;
    logic        is_err;
    logic        to;
    logic [31:0] cur;
    logic        en;
    logic [31:0] brate;
  } exp_t;

  exp_t               sb[$];
  int                 checks = 0;
  int                 errors = 0;
  logic [NUM_REQ-1:0] pulse;
  logic               en_dropped;
  logic [31:0]        last_loaded;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // One cycle: sample at negedge and score any ack/err pulse.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!gen_en) en_dropped = 1'b1;
    pulse = ack | err;
    if (pulse != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 64'(pulse), 64'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("ack_r%0d", e.idx), 64'(ack), e.is_err ? 64'd0 : 64'(1 << e.idx));
        check($sformatf("err_r%0d", e.idx), 64'(err), e.is_err ? 64'(1 << e.idx) : 64'd0);
        if (e.is_err) check($sformatf("err_timeout_r%0d", e.idx), 64'(err_timeout), 64'(e.to));
        check($sformatf("owner_r%0d", e.idx), 64'(owner), 64'(e.idx));
        check($sformatf("cur_baud_r%0d", e.idx), 64'(cur_baud), 64'(e.cur));
        check($sformatf("gen_en_r%0d", e.idx), 64'(gen_en), 64'(e.en));
        check($sformatf("gen_baud_rate_r%0d", e.idx), 64'(gen_baud_rate), 64'(e.brate));
      end
    end
  endtask

  task automatic push_exp(input int idx, input logic is_err, input logic to,
                          input logic [31:0] cur, input logic en, input logic [31:0] brate);
    exp_t e;
    e = '{idx, is_err, to, cur, en, brate};
    sb.push_back(e);
  endtask

  task automatic apply(input int vn, input vec_t v);
    int n;
    push_exp(v.idx, v.is_err, v.to, v.cur, v.en, v.is_err ? last_loaded : v.rate);
    if (!v.is_err) last_loaded = v.rate;
    req_baud[32*v.idx +: 32] = v.rate;
    req[v.idx] = 1'b1;
    en_dropped = 1'b0;
    n = 0;
    pulse = '0;
    while (n < 200 && !pulse[v.idx]) begin
      tick();
      n++;
    end
    req[v.idx] = 1'b0;
    check($sformatf("v%0d_pulse_seen", vn), 64'(pulse[v.idx]), 64'd1);
    if (v.steady) begin
      check($sformatf("v%0d_steady_latency", vn), 64'(n), 64'd3);
      check($sformatf("v%0d_steady_en", vn), 64'(en_dropped), 64'd0);
    end
    tick();
    check($sformatf("v%0d_idle", vn), 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_owner"}, 64'(owner), 64'd0);
    check({tag, "_cur_baud"}, 64'(cur_baud), 64'd0);
    check({tag, "_gen_en"}, 64'(gen_en), 64'd0);
    check({tag, "_gen_baud_rate"}, 64'(gen_baud_rate), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int hi;
    logic seen_low;
    int acks_seen;

    // idx, rate, is_err, to, cur_baud after, gen_en after, steady
    vecs[0] = '{0, 32'd100, 1'b0, 1'b0, 32'd100, 1'b1, 1'b0};
    vecs[1] = '{1, 32'd100, 1'b0, 1'b0, 32'd100, 1'b1, 1'b1};
    vecs[2] = '{2, 32'd0,   1'b1, 1'b0, 32'd100, 1'b1, 1'b0};
    vecs[3] = '{2, 32'd600, 1'b1, 1'b0, 32'd100, 1'b1, 1'b0};
    vecs[4] = '{3, 32'd500, 1'b0, 1'b0, 32'd500, 1'b1, 1'b0};
    vecs[5] = '{2, 32'd501, 1'b1, 1'b0, 32'd500, 1'b1, 1'b0};
    vecs[6] = '{1, 32'd250, 1'b0, 1'b0, 32'd250, 1'b1, 1'b0};
    vecs[7] = '{3, 32'd250, 1'b0, 1'b0, 32'd250, 1'b1, 1'b1};

    rst_n       = 1'b0;
    req         = '0;
    req_baud    = '0;
    tick_kill   = 1'b0;
    last_loaded = '0;
    en_dropped  = 1'b0;
    pulse       = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) apply(i, vecs[i]);

    // Simultaneous requests 0, 1, 3 with the pointer back at 0.
    req_baud[0  +: 32] = 32'd100;
    req_baud[32 +: 32] = 32'd200;
    req_baud[96 +: 32] = 32'd500;
    push_exp(0, 1'b0, 1'b0, 32'd100, 1'b1, 32'd100);
    push_exp(1, 1'b0, 1'b0, 32'd200, 1'b1, 32'd200);
    push_exp(3, 1'b0, 1'b0, 32'd500, 1'b1, 32'd500);
    last_loaded = 32'd500;
    req = 4'b1011;
    acks_seen = 0;
    n = 0;
    while (n < 300 && acks_seen < 3) begin
      tick();
      n++;
      if (pulse != '0) begin
        acks_seen++;
        req = req & ~pulse;
      end
    end
    req = '0;
    check("rr_three_acks", 64'(acks_seen), 64'd3);
    tick();

    // First-tick timeout: 2*10+4 cycles of enabled wait, then err[0].
    tick_kill = 1'b1;
    req_baud[0 +: 32] = 32'd100;
    push_exp(0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd100);
    last_loaded = 32'd100;
    req[0] = 1'b1;
    n = 0;
    hi = 0;
    seen_low = 1'b0;
    pulse = '0;
    while (n < 200 && !pulse[0]) begin
      tick();
      n++;
      if (!gen_en) seen_low = 1'b1;
      else if (seen_low) hi++;
    end
    req[0] = 1'b0;
    check("timeout_pulse_seen", 64'(pulse[0]), 64'd1);
    check("timeout_wait_cycles", 64'(hi), 64'd24);
    tick_kill = 1'b0;
    tick();

    // Reset during DISABLE: everything clears at once, no pulse.
    req_baud[64 +: 32] = 32'd200;
    req[2] = 1'b1;
    tick();
    tick();
    check("pre_reset_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_disable");
    req = '0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    last_loaded = '0;
    tick();

    // Reset during WAIT_TICK.
    tick_kill = 1'b1;
    req_baud[96 +: 32] = 32'd100;
    req[3] = 1'b1;
    n = 0;
    while (n < 60 && !gen_en) begin
      tick();
      n++;
    end
    check("wait_tick_reached", 64'(gen_en), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_wait_tick");
    req = '0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick_kill = 1'b0;
    last_loaded = '0;
    tick();

    // Fresh request after reset completes normally (divisor 4).
    apply(8, '{1, 32'd250, 1'b0, 1'b0, 32'd250, 1'b1, 1'b0});
    check("final_divisor", 64'(gen_baud_cycle), 64'd4);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
